serial_adder_host: RTL and testbench

- Host-side endpoint of the serial adder link, facing the serial adder DUT.
- Accepts a parallel operand pair over a valid/ready handshake.
- Serializes both operands onto ina/inb, framed by en_i.
- Captures the serial sum the adder returns on out, framed by en_o, and presents it as a parallel result over a second valid/ready handshake, with a timeout/framing error flag. It sits between a parallel test or stimulus source and the serial adder.

---
 rtl/adder_pkg.sv | 19 +
 rtl/serial_shift_piso.sv | 33 +++
 rtl/serial_adder_host.sv | 171 +++++++++++++++++
 tb/tb_serial_adder_host.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and constants for the host end of the serial adder link.
package adder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT,
    RECV,
    DONE
  } host_state_e;

  localparam int DEFAULT_TIMEOUT = 16;

  // The sum of two op_w-bit operands needs one extra bit for the carry.
  function automatic int res_width(input int op_w);
    return op_w + 1;
  endfunction

endpackage

// File: rtl/serial_shift_piso.sv
// Parallel-in / serial-out shifter, LSB first, with a registered serial output.
module serial_shift_piso #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic         clr_i,
  input  logic [W-1:0] data_i,
  output logic         sout_o
);

  logic [W-1:0] sh_q;
  logic         sout_q;

  // Bit 0 goes straight to the output on load; the rest waits in sh_q.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      sh_q   <= '0;
      sout_q <= 1'b0;
    end else if (load_i) begin
      sh_q   <= data_i >> 1;
      sout_q <= data_i[0];
    end else if (shift_i) begin
      sh_q   <= sh_q >> 1;
      sout_q <= sh_q[0];
    end
  end

  assign sout_o = sout_q;

endmodule

// File: rtl/serial_adder_host.sv
// Host endpoint for the serial adder: serializes an operand pair, then
// collects the serial sum frame and hands it back with an error flag.
module serial_adder_host
  import adder_pkg::*;
#(
  parameter int OP_W    = 2,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         op_valid,
  output logic                         op_ready,
  input  logic [OP_W-1:0]              op_a,
  input  logic [OP_W-1:0]              op_b,
  output logic                         en_i,
  output logic                         ina,
  output logic                         inb,
  input  logic                         en_o,
  input  logic                         out,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic [res_width(OP_W)-1:0]   res_sum,
  output logic                         res_err
);

  localparam int RES_W = res_width(OP_W);
  localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam int IDX_W = $clog2(RES_W);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  host_state_e      state_q, state_d;
  logic [CNT_W-1:0] send_cnt_q, send_cnt_d;
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RES_W-1:0] rx_q, rx_d, rx_cap;
  logic [RES_W-1:0] res_sum_q, res_sum_d;
  logic             res_valid_q, res_valid_d;
  logic             res_err_q, res_err_d;
  logic             op_ready_q, op_ready_d;
  logic             en_i_q, en_i_d;
  logic             piso_load, piso_shift, piso_clr;

  serial_shift_piso #(.W(OP_W)) u_piso_a (
    .clk(clk), .rst(rst), .load_i(piso_load), .shift_i(piso_shift),
    .clr_i(piso_clr), .data_i(op_a), .sout_o(ina)
  );

  serial_shift_piso #(.W(OP_W)) u_piso_b (
    .clk(clk), .rst(rst), .load_i(piso_load), .shift_i(piso_shift),
    .clr_i(piso_clr), .data_i(op_b), .sout_o(inb)
  );

  // Receive word with the incoming bit merged in at the current index.
  for (genvar gi = 0; gi < RES_W; gi++) begin : g_rx_cap
    assign rx_cap[gi] = (idx_q == IDX_W'(gi)) ? out : rx_q[gi];
  end

  always_comb begin
    state_d     = state_q;
    send_cnt_d  = send_cnt_q;
    tmo_cnt_d   = tmo_cnt_q;
    idx_d       = idx_q;
    rx_d        = rx_q;
    res_sum_d   = res_sum_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    en_i_d      = 1'b0;
    piso_load   = 1'b0;
    piso_shift  = 1'b0;
    piso_clr    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (op_valid && op_ready_q) begin
          state_d    = SEND;
          piso_load  = 1'b1;
          send_cnt_d = '0;
          idx_d      = '0;
          rx_d       = '0;
          en_i_d     = 1'b1;
        end
      end
      SEND: begin
        if (send_cnt_q == CNT_W'(OP_W - 1)) begin
          state_d   = WAIT;
          piso_clr  = 1'b1;
          tmo_cnt_d = '0;
        end else begin
          piso_shift = 1'b1;
          send_cnt_d = send_cnt_q + CNT_W'(1);
          en_i_d     = 1'b1;
        end
      end
      WAIT: begin
        // A reply takes priority over a timeout landing in the same cycle.
        if (en_o) begin
          rx_d[0] = out;
          idx_d   = IDX_W'(1);
          state_d = RECV;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_sum_d   = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
      end
      RECV: begin
        if (en_o) begin
          rx_d = rx_cap;
          if (idx_q == IDX_W'(RES_W - 1)) begin
            state_d     = DONE;
            res_valid_d = 1'b1;
            res_err_d   = 1'b0;
            res_sum_d   = rx_cap;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          state_d     = DONE;
          res_valid_d = 1'b1;
          res_err_d   = 1'b1;
          res_sum_d   = '0;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_d     = IDLE;
          res_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    op_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      send_cnt_q  <= '0;
      tmo_cnt_q   <= '0;
      idx_q       <= '0;
      rx_q        <= '0;
      res_sum_q   <= '0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
      op_ready_q  <= 1'b0;
      en_i_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      send_cnt_q  <= send_cnt_d;
      tmo_cnt_q   <= tmo_cnt_d;
      idx_q       <= idx_d;
      rx_q        <= rx_d;
      res_sum_q   <= res_sum_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
      op_ready_q  <= op_ready_d;
      en_i_q      <= en_i_d;
    end
  end

  assign op_ready  = op_ready_q;
  assign en_i      = en_i_q;
  assign res_valid = res_valid_q;
  assign res_sum   = res_sum_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_serial_adder_host.sv
// Directed bench for serial_adder_host: the bench plays the serial adder and
// both parallel endpoints, comparing against hand-computed values.
module tb_serial_adder_host;

  logic       clk = 1'b0;
  logic       rst, op_valid, op_ready, en_i, ina, inb;
  logic       en_o, out, res_valid, res_ready, res_err;
  logic [1:0] op_a, op_b;
  logic [2:0] res_sum;
  int         vectors = 0;
  int         miscompares = 0;

  always #5 clk = ~clk;

  serial_adder_host #(.OP_W(2), .TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .en_i(en_i), .ina(ina), .inb(inb),
    .en_o(en_o), .out(out), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_err(res_err)
  );

  // Offer a pair at a falling edge; returns one falling edge after acceptance.
  task automatic offer(input logic [1:0] a, input logic [1:0] b);
    int n = 0;
    while (op_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (op_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL offer_ready: op_ready=%b, expected 1", op_ready);
    end
    op_a = a; op_b = b; op_valid = 1'b1;
    @(negedge clk);
    op_valid = 1'b0;
  endtask

  // Adder reply: nbits frame bits LSB first, one per cycle.
  task automatic send_frame(input logic [2:0] s, input int nbits);
    for (int k = 0; k < nbits; k++) begin
      en_o = 1'b1; out = s[k];
      @(negedge clk);
    end
    en_o = 1'b0; out = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0;
    en_o = 1'b0; out = 1'b0; res_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    vectors++;
    if ({en_i, ina, inb, op_ready, res_valid, res_err, res_sum} !== 9'b0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b, expected 000000000",
               {en_i, ina, inb, op_ready, res_valid, res_err, res_sum});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({op_ready, en_i, res_valid} !== 3'b100) begin
      miscompares++;
      $display("FAIL reset_release: op_ready/en_i/res_valid=%b, expected 100",
               {op_ready, en_i, res_valid});
    end
    $display("reset: done");
  endtask

  task automatic test_basic_add;
    offer(2'b11, 2'b01);
    vectors++;
    if ({en_i, ina, inb, op_ready} !== 4'b1110) begin
      miscompares++;
      $display("FAIL basic_bit0: en_i/ina/inb/op_ready=%b, expected 1110", {en_i, ina, inb, op_ready});
    end
    @(negedge clk);
    vectors++;
    if ({en_i, ina, inb} !== 3'b110) begin
      miscompares++;
      $display("FAIL basic_bit1: en_i/ina/inb=%b, expected 110", {en_i, ina, inb});
    end
    @(negedge clk);
    vectors++;
    if ({en_i, ina, inb} !== 3'b000) begin
      miscompares++;
      $display("FAIL basic_frame_end: en_i/ina/inb=%b, expected 000", {en_i, ina, inb});
    end
    en_o = 1'b1; out = 1'b0; @(negedge clk);
    out = 1'b0; @(negedge clk);
    out = 1'b1;
    vectors++;
    if (res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_early_valid: res_valid=%b, expected 0", res_valid);
    end
    @(negedge clk);
    en_o = 1'b0; out = 1'b0;
    vectors++;
    if ({res_valid, res_err, res_sum} !== 5'b10100) begin
      miscompares++;
      $display("FAIL basic_result: valid/err/sum=%b, expected 10100", {res_valid, res_err, res_sum});
    end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    vectors++;
    if ({res_valid, op_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL basic_release: res_valid/op_ready=%b, expected 01", {res_valid, op_ready});
    end
    $display("basic_add: 3+1 -> sum=%0d err=%0d", res_sum, res_err);
  endtask

  task automatic test_back_to_back;
    offer(2'd1, 2'd2);
    @(negedge clk);
    @(negedge clk);
    send_frame(3'd3, 3);
    op_a = 2'd3; op_b = 2'd3; op_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({res_valid, res_err, res_sum, op_ready} !== 6'b100110) begin
        miscompares++;
        $display("FAIL b2b_hold%0d: valid/err/sum/op_ready=%b, expected 100110", i,
                 {res_valid, res_err, res_sum, op_ready});
      end
      @(negedge clk);
    end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    vectors++;
    if ({res_valid, op_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_release: res_valid/op_ready=%b, expected 01", {res_valid, op_ready});
    end
    @(negedge clk);
    op_valid = 1'b0;
    vectors++;
    if ({en_i, ina, inb, op_ready} !== 4'b1110) begin
      miscompares++;
      $display("FAIL b2b_second_accept: en_i/ina/inb/op_ready=%b, expected 1110", {en_i, ina, inb, op_ready});
    end
    @(negedge clk);
    @(negedge clk);
    send_frame(3'd6, 3);
    vectors++;
    if ({res_valid, res_err, res_sum} !== 5'b10110) begin
      miscompares++;
      $display("FAIL b2b_second_result: valid/err/sum=%b, expected 10110", {res_valid, res_err, res_sum});
    end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    $display("back_to_back: 1+2 then 3+3 -> last sum=%0d", res_sum);
  endtask

  task automatic test_timeout;
    int waited = 0;
    offer(2'd1, 2'd1);
    @(negedge clk);
    @(negedge clk);
    while (res_valid !== 1'b1 && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    vectors++;
    if (waited != 16) begin
      miscompares++;
      $display("FAIL timeout_cycles: waited %0d, expected 16", waited);
    end
    vectors++;
    if ({res_valid, res_err, res_sum} !== 5'b11000) begin
      miscompares++;
      $display("FAIL timeout_result: valid/err/sum=%b, expected 11000", {res_valid, res_err, res_sum});
    end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    $display("timeout: waited=%0d err=%0d", waited, res_err);
  endtask

  task automatic test_short_frame;
    offer(2'd2, 2'd1);
    @(negedge clk);
    @(negedge clk);
    send_frame(3'b011, 2);
    @(negedge clk);
    vectors++;
    if ({res_valid, res_err, res_sum} !== 5'b11000) begin
      miscompares++;
      $display("FAIL short_frame: valid/err/sum=%b, expected 11000", {res_valid, res_err, res_sum});
    end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    $display("short_frame: err=%0d sum=%0d", res_err, res_sum);
  endtask

  task automatic test_late_reply;
    logic early = 1'b0;
    offer(2'd2, 2'd3);
    en_o = 1'b1; out = 1'b1;
    @(negedge clk);
    @(negedge clk);
    en_o = 1'b0; out = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (res_valid !== 1'b0) early = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (early !== 1'b0) begin
      miscompares++;
      $display("FAIL late_premature_valid: res_valid seen=%b, expected 0", early);
    end
    send_frame(3'b101, 3);
    vectors++;
    if ({res_valid, res_err, res_sum} !== 5'b10101) begin
      miscompares++;
      $display("FAIL late_result: valid/err/sum=%b, expected 10101", {res_valid, res_err, res_sum});
    end
    res_ready = 1'b1; @(negedge clk); res_ready = 1'b0;
    $display("late_reply: 2+3 -> sum=%0d err=%0d", res_sum, res_err);
  endtask

  task automatic test_reset_mid_send;
    logic stray = 1'b0;
    offer(2'd3, 2'd3);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({en_i, ina, inb, op_ready, res_valid} !== 5'b0) begin
      miscompares++;
      $display("FAIL midsend_reset: en_i/ina/inb/op_ready/res_valid=%b, expected 00000",
               {en_i, ina, inb, op_ready, res_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({op_ready, res_valid} !== 2'b10) begin
      miscompares++;
      $display("FAIL midsend_recover: op_ready/res_valid=%b, expected 10", {op_ready, res_valid});
    end
    for (int i = 0; i < 4; i++) begin
      if (res_valid !== 1'b0 || en_i !== 1'b0) stray = 1'b1;
      @(negedge clk);
    end
    vectors++;
    if (stray !== 1'b0) begin
      miscompares++;
      $display("FAIL midsend_stray_activity: seen=%b, expected 0", stray);
    end
    $display("reset_mid_send: op_ready=%0d", op_ready);
  endtask

  initial begin
    rst = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0;
    en_o = 1'b0; out = 1'b0; res_ready = 1'b0;
    test_reset;
    test_basic_add;
    test_back_to_back;
    test_timeout;
    test_short_frame;
    test_late_reply;
    test_reset_mid_send;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
